// File: rtl/ascii_pkg.sv
// rtl/ascii_pkg.sv - shared defaults, FSM states, FIFO entry layout and printable-range helper for ascii_packer
package ascii_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_WORD_CHARS = 4;
  localparam int DEF_FIFO_DEPTH = 8;

  localparam logic [7:0] PRINT_MIN = 8'h20;
  localparam logic [7:0] PRINT_MAX = 8'h7E;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DRAIN
  } state_t;

  // Field order matches the flat vector the packer pushes: {last, bytes, word}
  typedef struct packed {
    logic                                     last;
    logic [$clog2(DEF_WORD_CHARS):0]          bytes;
    logic [DEF_DATA_WIDTH*DEF_WORD_CHARS-1:0] word;
  } fifo_entry_t;

  function automatic logic is_printable(input logic [7:0] c);
    return (c >= PRINT_MIN) && (c <= PRINT_MAX);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - show-ahead synchronous FIFO; head reads as zero when empty, overflow reported as a drop pulse
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_wr,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_rd,
  output logic             o_empty,
  output logic             o_drop,
  output logic [WIDTH-1:0] o_data
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_full;
  logic             w_pop;
  logic             w_push;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop   = i_rd && !o_empty;
  // A pop in the same cycle frees the slot, so a write into a full FIFO still lands
  assign w_push  = i_wr && (!w_full || w_pop);
  assign o_drop  = i_wr && w_full && !w_pop;
  assign o_data  = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/ascii_packer.sv
// rtl/ascii_packer.sv - packs decoded ASCII chars into words behind a show-ahead FIFO
// ASCII_PACKER_FILTER_EN: when defined, chars outside 0x20..0x7E are ignored.
module ascii_packer
  import ascii_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int WORD_CHARS = DEF_WORD_CHARS,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  input  logic [DATA_WIDTH-1:0]            in_char,
  input  logic                             in_done,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [DATA_WIDTH*WORD_CHARS-1:0] out_word,
  output logic [$clog2(WORD_CHARS):0]      out_bytes,
  output logic                             out_last,
  output logic                             busy,
  output logic                             err
);

  localparam int BW = $clog2(WORD_CHARS) + 1;
  localparam int WW = DATA_WIDTH * WORD_CHARS;
  localparam int EW = 1 + BW + WW;

  state_t          r_state;
  state_t          w_state_next;
  logic [BW-1:0]   r_cnt;
  logic [BW-1:0]   w_cnt_next;
  logic [BW-1:0]   w_cnt_inc;
  logic [WW-1:0]   r_word;
  logic [WW-1:0]   w_word_next;
  logic [WW-1:0]   w_lane_word;
  logic            w_accept;
  logic            w_push;
  logic [EW-1:0]   w_push_data;
  logic            r_push;
  logic [EW-1:0]   r_push_data;
  logic            w_violation;
  logic            r_err;
  logic            w_fifo_empty;
  logic            w_fifo_drop;
  logic [EW-1:0]   w_fifo_data;

`ifdef ASCII_PACKER_FILTER_EN
  assign w_accept = in_valid && is_printable(8'(in_char));
`else
  assign w_accept = in_valid;
`endif

  assign w_cnt_inc = r_cnt + {{(BW-1){1'b0}}, w_accept};

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_word_next  = r_word;
    w_push       = 1'b0;
    w_push_data  = '0;
    w_violation  = 1'b0;
    w_lane_word  = r_word;
    for (int i = 0; i < WORD_CHARS; i++) begin
      if (w_accept && (r_cnt == BW'(i))) w_lane_word[i*DATA_WIDTH +: DATA_WIDTH] = in_char;
    end
    case (r_state)
      // IDLE behaves as COLLECT with an empty word, so a char and a done can share a cycle
      IDLE, COLLECT: begin
        if (in_done) begin
          w_push       = 1'b1;
          w_push_data  = {1'b1, w_cnt_inc, w_lane_word};
          w_cnt_next   = '0;
          w_word_next  = '0;
          w_state_next = DRAIN;
        end else if (w_accept) begin
          w_state_next = COLLECT;
          if (r_cnt == BW'(WORD_CHARS - 1)) begin
            w_push      = 1'b1;
            w_push_data = {1'b0, BW'(WORD_CHARS), w_lane_word};
            w_cnt_next  = '0;
            w_word_next = '0;
          end else begin
            w_cnt_next  = w_cnt_inc;
            w_word_next = w_lane_word;
          end
        end
      end
      DRAIN: begin
        w_violation = in_valid || in_done;
        // r_push still holds the flush word on the first DRAIN cycle
        if (w_fifo_empty && !r_push) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_word      <= '0;
      r_push      <= 1'b0;
      r_push_data <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_word      <= w_word_next;
      r_push      <= w_push;
      r_push_data <= w_push_data;
      r_err       <= r_err | w_violation | w_fifo_drop;
    end
  end

  sync_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_wr    (r_push),
    .i_data  (r_push_data),
    .i_rd    (out_ready),
    .o_empty (w_fifo_empty),
    .o_drop  (w_fifo_drop),
    .o_data  (w_fifo_data)
  );

  assign out_valid                      = !w_fifo_empty;
  assign {out_last, out_bytes, out_word} = w_fifo_data;
  assign busy                           = (r_state != IDLE);
  assign err                            = r_err;

endmodule

// File: tb/tb_ascii_packer.sv
// tb/tb_ascii_packer.sv - scoreboard bench for ascii_packer: directed stimulus, monitor pops expected words
module tb_ascii_packer;
  import ascii_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_char;
  logic        in_done;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_word;
  logic [2:0]  out_bytes;
  logic        out_last;
  logic        busy;
  logic        err;

  int n_checks = 0;
  int n_errors = 0;
  fifo_entry_t exp_q[$];

  ascii_packer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_char   (in_char),
    .in_done   (in_done),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_word  (out_word),
    .out_bytes (out_bytes),
    .out_last  (out_last),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_word(input logic [31:0] w, input logic [2:0] b, input logic l);
    fifo_entry_t e;
    e.word  = w;
    e.bytes = b;
    e.last  = l;
    exp_q.push_back(e);
  endtask

  // Monitor: one pop per handshake observed mid-cycle
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_word", {out_last, out_bytes, out_word}, 64'h0);
      end else begin
        fifo_entry_t e;
        e = exp_q.pop_front();
        chk("word",  out_word,  e.word);
        chk("bytes", out_bytes, e.bytes);
        chk("last",  out_last,  e.last);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] c, input logic done);
    in_valid = 1'b1;
    in_char  = c;
    in_done  = done;
    tick();
    in_valid = 1'b0;
    in_done  = 1'b0;
  endtask

  task automatic done_only();
    in_done = 1'b1;
    tick();
    in_done = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 100 && (busy || out_valid); i++) tick();
    chk(name, {busy, out_valid}, 2'b00);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_char   = 8'h00;
    in_done   = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_word",  out_word,  32'h0);
    chk("rst_out_bytes", out_bytes, 3'd0);
    chk("rst_out_last",  out_last,  1'b0);
    chk("rst_busy",      busy,      1'b0);
    chk("rst_err",       err,       1'b0);
    rst = 1'b0;
    tick();

    // HELLO then a separate done
    expect_word(32'h4C4C4548, 3'd4, 1'b0);
    expect_word(32'h0000004F, 3'd1, 1'b1);
    send("H", 0); send("E", 0); send("L", 0); send("L", 0); send("O", 0);
    done_only();
    wait_idle("hello_idle");
    chk("hello_err", err, 1'b0);

    // ABCD with done on D; word appears one edge after completion
    expect_word(32'h44434241, 3'd4, 1'b1);
    send("A", 0); send("B", 0); send("C", 0);
    send("D", 1);
    chk("latency_not_yet", out_valid, 1'b0);
    chk("latency_busy",    busy,      1'b1);
    tick();
    chk("latency_valid",   out_valid, 1'b1);
    wait_idle("abcd_idle");

    // done with no chars: zero-byte last marker
    expect_word(32'h0, 3'd0, 1'b1);
    done_only();
    chk("empty_busy", busy, 1'b1);
    wait_idle("empty_idle");
    chk("empty_busy_after", busy, 1'b0);

    // Non-printable char in the middle
`ifdef ASCII_PACKER_FILTER_EN
    expect_word(32'h00004241, 3'd2, 1'b1);
`else
    expect_word(32'h00420A41, 3'd3, 1'b1);
`endif
    send("A", 0); send(8'h0A, 0); send("B", 0);
    done_only();
    wait_idle("filter_idle");

    // Reset mid-word discards the partial word
    send("Q", 0); send("R", 0);
    do_reset();
    chk("midrst_valid", out_valid, 1'b0);
    chk("midrst_word",  out_word,  32'h0);
    chk("midrst_busy",  busy,      1'b0);
    chk("midrst_err",   err,       1'b0);
    expect_word(32'h5A595857, 3'd4, 1'b1);
    send("W", 0); send("X", 0); send("Y", 0);
    send("Z", 1);
    wait_idle("wxyz_idle");

    // Overflow: 9 words into an 8-deep FIFO with the consumer stalled
    out_ready = 1'b0;
    for (int k = 0; k < 8; k++)
      expect_word({8'(8'h33 + 4*k), 8'(8'h32 + 4*k), 8'(8'h31 + 4*k), 8'(8'h30 + 4*k)}, 3'd4, 1'b0);
    for (int i = 0; i < 36; i++) send(8'(8'h30 + i), 0);
    tick();
    tick();
    chk("ovf_err",   err,       1'b1);
    chk("ovf_valid", out_valid, 1'b1);
    chk("ovf_head",  out_word,  32'h33323130);
    out_ready = 1'b1;
    for (int i = 0; i < 50 && out_valid; i++) tick();
    chk("ovf_drained", out_valid, 1'b0);
    chk("ovf_busy",    busy,      1'b1);
    do_reset();
    chk("ovf_rst_err", err, 1'b0);

    // Char during DRAIN is dropped and flagged
    out_ready = 1'b0;
    expect_word(32'h0, 3'd0, 1'b1);
    done_only();
    send("Z", 0);
    tick();
    chk("drain_err", err, 1'b1);
    out_ready = 1'b1;
    wait_idle("drain_idle");

    tick();
    tick();
    chk("sb_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
